spi_tx_rx_seq: RTL and testbench
================================

Name: spi_tx_rx_seq

Overview:
SPI mode-0 master sequencer for the SPI block. It drives the select line of a chain of mux-flop shift cells: parallel-load on start, then one serial shift per SCLK falling edge. It also generates SCLK and CS_N, samples MISO into a receive register, and reports completion.
It sits between the frame producer and the off-chip SPI pins.

Parameters:
DATA_W, 16, frame width in bits (>=2), MSB first.
CLK_DIV, 4, clk cycles per SCLK half-period (>=1); also CS setup and hold length.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  synchronous reset, active-high.
start  input  1  request a frame; honoured only in IDLE.
din  input  DATA_W  parallel transmit word, captured in the LOAD cycle.
miso  input  1  serial data from slave.
mosi  output  1  serial data to slave = tx shift chain MSB.
sclk  output  1  SPI clock, CPOL=0.
cs_n  output  1  slave select, active-low.
busy  output  1  high from LOAD through DONE inclusive.
done  output  1  one-cycle pulse at frame end.
dout  output  DATA_W  last received word, updated in the DONE cycle.

Behaviour:
- Reset: clk is clk; reset is rst, synchronous, active-high. On reset: state=IDLE, sclk=0, cs_n=1, busy=0, done=0, dout=0, tx chain=0, counters=0. Reset mid-frame aborts on the next edge: cs_n=1, sclk=0, no done pulse.
- States: IDLE, LOAD, LEAD, SHIFT_LO, SHIFT_HI, TRAIL, DONE.
- IDLE: start=1 -> LOAD. Otherwise hold. cs_n=1, sclk=0.
- LOAD (1 cycle): shift-cell select=1, so the chain loads din. cs_n=1. Next state is LEAD.
- LEAD (CLK_DIV cycles): cs_n=0, sclk=0. mosi already shows din[DATA_W-1]. Next state is SHIFT_LO.
- SHIFT_LO (CLK_DIV cycles): sclk=0. On exit, rx <= {rx[DATA_W-2:0], miso}; this is the sample on the SCLK rising edge. Next state is SHIFT_HI.
- SHIFT_HI (CLK_DIV cycles): sclk=1.
  - On exit, bit_cnt increments.
  - If bit_cnt != DATA_W-1: shift-cell select=0 with shift enable for exactly one cycle (the falling edge), then SHIFT_LO.
  - Else: no shift, go to TRAIL.
- TRAIL (CLK_DIV cycles): sclk=0, cs_n=0. Next state is DONE.
- DONE (1 cycle): cs_n=1, done=1, dout<=rx. Next state is IDLE.
- start outside IDLE is ignored, including in the DONE cycle. No queueing.
- Latency: with E0 the edge that samples start, done is high in the cycle after edge E0+1+2*CLK_DIV*(DATA_W+1). For the defaults that is edge E0+137.
- Exactly DATA_W rising and DATA_W falling SCLK edges per frame. The last falling edge is the entry to TRAIL. There are DATA_W-1 shift pulses to the chain.
- Counters:
  - div_cnt width = clog2(CLK_DIV)+1, saturating compare at CLK_DIV-1, reset to 0 on every state change.
  - bit_cnt width = clog2(DATA_W)+1, cleared in LOAD.
- sclk, cs_n, mosi are registered outputs (glitch-free).
- din is sampled only in LOAD. Changes afterwards have no effect. miso is sampled only at SHIFT_LO exit.

Decomposition:
- Shared package spi_pkg:
  - state enum spi_state_t (IDLE..DONE)
  - mode constants CPOL=0, CPHA=0
  - helper function for counter widths.
- One natural sub-module: spi_shift_cell, a 1-bit mux-flop with load/shift select and sync reset. It is instantiated DATA_W times in a generate loop to form the tx chain. The sequencer owns the select and enable.

Test Plan:
1. Loopback (miso=mosi), din=16'hA5C3, start pulse -> 16 sclk rising edges, mosi sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; dout=16'hA5C3; done exactly at E0+137; cs_n low for edges E0+2..E0+136.
2. miso tied 1, din=16'h0000 -> mosi constant 0, dout=16'hFFFF. miso tied 0 -> dout=16'h0000.
3. start re-asserted at cycles E0+10 and in the DONE cycle, din changed mid-frame -> single frame only, transmitted word is the original din, next start accepted only once IDLE is reached.
4. rst=1 at E0+50 for one cycle -> next cycle cs_n=1, sclk=0, busy=0; no done pulse; dout=0. A new start afterwards completes normally.
5. Parameter sweep CLK_DIV=1, DATA_W=8, loopback din=8'h81 -> sclk period 2 clk, done at E0+19, dout=8'h81.
6. Checker on all runs: sclk never toggles while cs_n=1; exactly DATA_W-1 shift pulses per frame; busy continuous from LOAD to DONE.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master sequencer.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        LEAD     = 3'd2,
        SHIFT_LO = 3'd3,
        SHIFT_HI = 3'd4,
        TRAIL    = 3'd5,
        DONE     = 3'd6
    } spi_state_t;

    // SPI mode 0: SCLK idles low, sample on rising edge, launch on falling edge.
    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

    // Counter width able to hold 0..n.
    function automatic int unsigned cnt_w(input int unsigned n);
        return 32'($clog2(n)) + 32'd1;
    endfunction

endpackage

// File: rtl/spi_shift_cell.sv
// One bit of the transmit chain: mux-flop choosing parallel load or serial shift.
module spi_shift_cell (
    input  logic clk,
    input  logic rst,
    input  logic sel,
    input  logic en,
    input  logic load_bit,
    input  logic shift_bit,
    output logic q
);

    // sel=1 loads the parallel bit, sel=0 takes the neighbour's bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else if (en) begin
            q <= sel ? load_bit : shift_bit;
        end
    end

endmodule

// File: rtl/spi_tx_rx_seq.sv
// SPI mode-0 master sequencer: drives the tx shift chain, SCLK, CS_N and captures MISO.
module spi_tx_rx_seq
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    input  logic              miso,
    output logic              mosi,
    output logic              sclk,
    output logic              cs_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] dout
);

    localparam int unsigned BIT_W = cnt_w(DATA_W);
    localparam int unsigned DIV_W = cnt_w(CLK_DIV);

    spi_state_t        state;
    spi_state_t        state_nxt;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic              tick;
    logic              last;

    logic [DATA_W-1:0] tx_chain;
    logic [DATA_W-1:0] shift_in;
    logic [DATA_W-1:0] rx;

    logic              cell_sel;
    logic              cell_en;
    logic              shift_pulse;
    logic              rx_en;
    logic              dout_en;
    logic              sclk_d;
    logic              cs_n_d;
    logic              busy_d;
    logic              done_d;

    assign tick     = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign last     = (bit_cnt == BIT_W'(DATA_W - 1));
    assign shift_in = {tx_chain[DATA_W-2:0], 1'b0};
    assign mosi     = tx_chain[DATA_W-1];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; timed phases advance when the divider reaches CLK_DIV-1.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (start) state_nxt = LOAD;
            LOAD:     state_nxt = LEAD;
            LEAD:     if (tick) state_nxt = SHIFT_LO;
            SHIFT_LO: if (tick) state_nxt = SHIFT_HI;
            SHIFT_HI: if (tick) state_nxt = last ? TRAIL : SHIFT_LO;
            TRAIL:    if (tick) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Output decode: pin values follow the upcoming state so the registered pins align with it.
    always_comb begin
        cell_sel    = 1'b0;
        shift_pulse = 1'b0;
        rx_en       = 1'b0;
        dout_en     = 1'b0;
        sclk_d      = CPOL;
        cs_n_d      = 1'b1;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        cell_sel    = (state == LOAD);
        shift_pulse = (state == SHIFT_HI) && tick && !last;
        rx_en       = (state == SHIFT_LO) && tick;
        dout_en     = (state_nxt == DONE) && (state != DONE);
        sclk_d      = CPOL ^ (state_nxt == SHIFT_HI);
        cs_n_d      = !(state_nxt inside {LEAD, SHIFT_LO, SHIFT_HI, TRAIL});
        busy_d      = (state_nxt != IDLE);
        done_d      = (state_nxt == DONE);
    end

    assign cell_en = cell_sel | shift_pulse;

    // Phase divider (cleared on each state change, saturating) and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            if (state_nxt != state) begin
                div_cnt <= '0;
            end else if (!tick) begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            if (state == LOAD) begin
                bit_cnt <= '0;
            end else if ((state == SHIFT_HI) && tick) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
        end
    end

    // Registered pins, receive shifter and result word.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk <= CPOL;
            cs_n <= 1'b1;
            busy <= 1'b0;
            done <= 1'b0;
            rx   <= '0;
            dout <= '0;
        end else begin
            sclk <= sclk_d;
            cs_n <= cs_n_d;
            busy <= busy_d;
            done <= done_d;
            if (rx_en) begin
                rx <= {rx[DATA_W-2:0], miso};
            end
            if (dout_en) begin
                dout <= rx;
            end
        end
    end

    // Transmit chain, MSB drives mosi.
    for (genvar i = 0; i < DATA_W; i++) begin : g_cell
        spi_shift_cell u_cell (
            .clk       (clk),
            .rst       (rst),
            .sel       (cell_sel),
            .en        (cell_en),
            .load_bit  (din[i]),
            .shift_bit (shift_in[i]),
            .q         (tx_chain[i])
        );
    end

endmodule

// File: tb/tb_spi_tx_rx_seq.sv
// Directed bench for spi_tx_rx_seq: default 16-bit/div-4 instance plus an 8-bit/div-1 instance.
module tb_spi_tx_rx_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 16-bit, CLK_DIV=4 instance
    logic        rst;
    logic        start;
    logic [15:0] din;
    logic        miso;
    logic        mosi;
    logic        sclk;
    logic        cs_n;
    logic        busy;
    logic        done;
    logic [15:0] dout;
    logic [1:0]  mmode;

    // 8-bit, CLK_DIV=1 instance (loopback)
    logic        rst8;
    logic        start8;
    logic [7:0]  din8;
    logic        miso8;
    logic        mosi8;
    logic        sclk8;
    logic        cs_n8;
    logic        busy8;
    logic        done8;
    logic [7:0]  dout8;

    // 0: loopback, 1: tied high, 2: tied low
    assign miso  = (mmode == 2'd0) ? mosi : (mmode == 2'd1);
    assign miso8 = mosi8;

    spi_tx_rx_seq u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .din   (din),
        .miso  (miso),
        .mosi  (mosi),
        .sclk  (sclk),
        .cs_n  (cs_n),
        .busy  (busy),
        .done  (done),
        .dout  (dout)
    );

    spi_tx_rx_seq #(.DATA_W(8), .CLK_DIV(1)) u_dut8 (
        .clk   (clk),
        .rst   (rst8),
        .start (start8),
        .din   (din8),
        .miso  (miso8),
        .mosi  (mosi8),
        .sclk  (sclk8),
        .cs_n  (cs_n8),
        .busy  (busy8),
        .done  (done8),
        .dout  (dout8)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 16-bit frame; optional start pokes / din change mid-frame.
    task automatic frame16(input string tag, input logic [15:0] w, input logic [15:0] exp_dout,
                           input bit poke);
        int          done_at = -1;
        int          rises   = 0;
        int          pulses  = 0;
        int          glitch  = 0;
        int          csn_bad = 0;
        int          busy_bad = 0;
        logic [15:0] mw      = '0;
        logic        psclk;
        din   = w;
        start = 1'b1;
        tick();                        // edge E0: now in LOAD
        start = 1'b0;
        chk({tag, "_load_busy"}, 32'(busy), 32'd1);
        chk({tag, "_load_csn"},  32'(cs_n), 32'd1);
        psclk = sclk;
        for (int i = 1; i <= 200; i++) begin
            if (poke && i == 11) start = 1'b1;
            if (poke && i == 12) start = 1'b0;
            if (poke && i == 21) din = ~w;
            if (u_dut.shift_pulse) pulses++;
            tick();                    // edge E0+i
            if (sclk && !psclk) begin
                rises++;
                mw = {mw[14:0], mosi};
            end
            if (cs_n && (sclk != psclk)) glitch++;
            psclk = sclk;
            if (!busy) busy_bad++;
            if (done) begin
                done_at = i;
                break;
            end
            if (cs_n) csn_bad++;
        end
        chk({tag, "_done_at"}, 32'(done_at), 32'd137);
        chk({tag, "_rises"},   32'(rises),   32'd16);
        chk({tag, "_mosi"},    32'(mw),      32'(w));
        chk({tag, "_dout"},    32'(dout),    32'(exp_dout));
        chk({tag, "_pulses"},  32'(pulses),  32'd15);
        chk({tag, "_csn_lo"},  32'(csn_bad), 32'd0);
        chk({tag, "_busy"},    32'(busy_bad), 32'd0);
        chk({tag, "_glitch"},  32'(glitch),  32'd0);
        chk({tag, "_csn_done"}, 32'(cs_n),   32'd1);
        if (poke) start = 1'b1;        // asserted in the DONE cycle, must be ignored
        tick();
        start = 1'b0;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_idle_busy"},  32'(busy), 32'd0);
        tick();
        tick();
        chk({tag, "_no_queue"}, 32'(busy), 32'd0);
    endtask

    // Frame aborted by a one-cycle reset at E0+50.
    task automatic abort16(input logic [15:0] w);
        int dones = 0;
        din   = w;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 50; i++) tick();
        rst = 1'b1;
        tick();                        // edge E0+50 samples reset
        rst = 1'b0;
        chk("abort_csn",  32'(cs_n), 32'd1);
        chk("abort_sclk", 32'(sclk), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_dout", 32'(dout), 32'd0);
        for (int i = 0; i < 150; i++) begin
            tick();
            if (done) dones++;
        end
        chk("abort_nodone", 32'(dones), 32'd0);
    endtask

    // One 8-bit frame on the CLK_DIV=1 instance.
    task automatic frame8(input logic [7:0] w);
        int         done_at = -1;
        int         rises   = 0;
        int         first_rise = -1;
        int         second_rise = -1;
        int         pulses  = 0;
        logic [7:0] mw      = '0;
        logic       psclk;
        din8   = w;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        psclk  = sclk8;
        for (int i = 1; i <= 60; i++) begin
            if (u_dut8.shift_pulse) pulses++;
            tick();
            if (sclk8 && !psclk) begin
                rises++;
                mw = {mw[6:0], mosi8};
                if (first_rise < 0) first_rise = i;
                else if (second_rise < 0) second_rise = i;
            end
            psclk = sclk8;
            if (done8) begin
                done_at = i;
                break;
            end
        end
        chk("f8_done_at", 32'(done_at), 32'd19);
        chk("f8_rises",   32'(rises),   32'd8);
        chk("f8_period",  32'(second_rise - first_rise), 32'd2);
        chk("f8_mosi",    32'(mw),      32'(w));
        chk("f8_dout",    32'(dout8),   32'(w));
        chk("f8_pulses",  32'(pulses),  32'd7);
        tick();
        chk("f8_idle", 32'(busy8), 32'd0);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        din    = '0;
        mmode  = 2'd0;
        rst8   = 1'b1;
        start8 = 1'b0;
        din8   = '0;
        tick();
        tick();
        rst  = 1'b0;
        rst8 = 1'b0;
        tick();

        chk("rst_csn",  32'(cs_n), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst8_csn", 32'(cs_n8), 32'd1);

        mmode = 2'd0;
        frame16("lb", 16'hA5C3, 16'hA5C3, 1'b0);

        mmode = 2'd1;
        frame16("one", 16'h0000, 16'hFFFF, 1'b0);

        mmode = 2'd2;
        frame16("zero", 16'hFFFF, 16'h0000, 1'b0);

        mmode = 2'd0;
        frame16("poke", 16'h3C5A, 16'h3C5A, 1'b1);

        abort16(16'h1234);
        frame16("post", 16'h8001, 16'h8001, 1'b0);

        frame8(8'h81);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
